// File: rtl/tx_response_arbiter.sv
// Shares one uart_tx between N_IF response sources: one holding slot per source,
// round-robin grant, and a two-byte frame (code, then data) with a per-byte done timeout.
module tx_response_arbiter #(
    parameter int unsigned N_IF        = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [N_IF-1:0]   i_Req_Valid,
    input  logic [8*N_IF-1:0] i_Req_Code,
    input  logic [8*N_IF-1:0] i_Req_Data,
    output logic [N_IF-1:0]   o_Req_Busy,
    output logic [N_IF-1:0]   o_Drop,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Done,
    output logic              o_Busy,
    output logic              o_Timeout
);

    localparam int unsigned   LW      = (N_IF > 1) ? $clog2(N_IF) : 1;
    localparam int unsigned   CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSendHi,
        StWaitHi,
        StSendLo,
        StWaitLo,
        StTimeout
    } state_e;

    state_e          state_q, state_d;
    logic [N_IF-1:0] pending_q, pending_d;
    logic [N_IF-1:0] drop_q, drop_d;
    logic [7:0]      slot_code_q [N_IF];
    logic [7:0]      slot_code_d [N_IF];
    logic [7:0]      slot_data_q [N_IF];
    logic [7:0]      slot_data_d [N_IF];
    logic [7:0]      work_data_q, work_data_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            grant;
    logic [LW-1:0]   grant_idx;
    logic [LW-1:0]   cand;

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == StIdle) begin
            for (int unsigned i = 1; i <= N_IF; i++) begin
                cand = LW'((32'(last_q) + i) % N_IF);
                if (!grant && pending_q[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        drop_d      = '0;
        slot_code_d = slot_code_q;
        slot_data_d = slot_data_q;
        work_data_d = work_data_q;
        tx_byte_d   = tx_byte_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        // Clearing the granted slot first lets a request arriving in its grant cycle land.
        if (grant) begin
            pending_d[grant_idx] = 1'b0;
        end
        for (int k = 0; k < N_IF; k++) begin
            if (i_Req_Valid[k]) begin
                if (!pending_d[k]) begin
                    pending_d[k]   = 1'b1;
                    slot_code_d[k] = i_Req_Code[8*k +: 8];
                    slot_data_d[k] = i_Req_Data[8*k +: 8];
                end else begin
                    drop_d[k] = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d     = StSendHi;
                    tx_byte_d   = slot_code_q[grant_idx];
                    work_data_d = slot_data_q[grant_idx];
                    last_d      = grant_idx;
                end
            end
            StSendHi: begin
                state_d = StWaitHi;
                cnt_d   = '0;
            end
            StSendLo: begin
                state_d = StWaitLo;
                cnt_d   = '0;
            end
            StWaitHi, StWaitLo: begin
                if (i_Tx_Done) begin
                    if (state_q == StWaitHi) begin
                        state_d   = StSendLo;
                        tx_byte_d = work_data_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StTimeout;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTimeout: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            drop_q      <= '0;
            slot_code_q <= '{default: '0};
            slot_data_q <= '{default: '0};
            work_data_q <= '0;
            tx_byte_q   <= '0;
            last_q      <= LW'(N_IF - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            slot_code_q <= slot_code_d;
            slot_data_q <= slot_data_d;
            work_data_q <= work_data_d;
            tx_byte_q   <= tx_byte_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_Req_Busy = pending_q;
    assign o_Drop     = drop_q;
    assign o_Tx_DV    = (state_q == StSendHi) || (state_q == StSendLo);
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Busy     = (state_q != StIdle);
    assign o_Timeout  = (state_q == StTimeout);

endmodule

// File: tb/tb_tx_response_arbiter.sv
// Bench for tx_response_arbiter: directed scenarios plus random traffic, all compared
// each cycle against a frame-level reference model built from the arbitration rules.
module tb_tx_response_arbiter;

    localparam int N_IF = 4;
    localparam int T    = 16;

    localparam int PH_IDLE    = 0;
    localparam int PH_SEND_HI = 1;
    localparam int PH_WAIT_HI = 2;
    localparam int PH_SEND_LO = 3;
    localparam int PH_WAIT_LO = 4;
    localparam int PH_TIMEOUT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_IF-1:0]   req_valid = '0;
    logic [8*N_IF-1:0] req_code = '0;
    logic [8*N_IF-1:0] req_data = '0;
    logic [N_IF-1:0]   req_busy;
    logic [N_IF-1:0]   drop;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_done = 1'b0;
    logic              busy;
    logic              timeout;

    always #5 clk = ~clk;

    tx_response_arbiter #(
        .N_IF       (N_IF),
        .TIMEOUT_CYC(T)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Req_Valid(req_valid),
        .i_Req_Code (req_code),
        .i_Req_Data (req_data),
        .o_Req_Busy (req_busy),
        .o_Drop     (drop),
        .o_Tx_DV    (tx_dv),
        .o_Tx_Byte  (tx_byte),
        .i_Tx_Done  (tx_done),
        .o_Busy     (busy),
        .o_Timeout  (timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [N_IF-1:0] m_pend = '0;
    logic [N_IF-1:0] m_drop = '0;
    logic [7:0]      m_code [N_IF] = '{default: '0};
    logic [7:0]      m_data [N_IF] = '{default: '0};
    logic [7:0]      m_byte = '0;
    logic [7:0]      m_cur = '0;
    int              m_last = N_IF - 1;
    int              m_ph = PH_IDLE;
    int              m_deadline = 0;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } dv_t;
    dv_t dv_log[$];

    int  cyc_no = 0;
    int  done_at = -1;
    bit  resp_en = 1'b1;
    bit  rand_dly = 1'b0;
    bit  spur = 1'b0;
    int  drop1_cnt = 0;

    task automatic model_update(input int now);
        int         g;
        int         k;
        bit         gr;
        logic [7:0] gc;
        logic [7:0] gd;
        if (rst) begin
            m_pend = '0;
            m_drop = '0;
            m_byte = '0;
            m_cur  = '0;
            m_last = N_IF - 1;
            m_ph   = PH_IDLE;
            return;
        end
        gr = 1'b0;
        g  = 0;
        if (m_ph == PH_IDLE) begin
            for (int i = 1; i <= N_IF; i++) begin
                k = (m_last + i) % N_IF;
                if (!gr && m_pend[k]) begin
                    gr = 1'b1;
                    g  = k;
                end
            end
        end
        gc = m_code[g];
        gd = m_data[g];
        if (gr) m_pend[g] = 1'b0;
        m_drop = '0;
        for (int j = 0; j < N_IF; j++) begin
            if (req_valid[j]) begin
                if (m_pend[j]) begin
                    m_drop[j] = 1'b1;
                end else begin
                    m_pend[j] = 1'b1;
                    m_code[j] = req_code[8*j +: 8];
                    m_data[j] = req_data[8*j +: 8];
                end
            end
        end
        case (m_ph)
            PH_IDLE: begin
                if (gr) begin
                    m_ph   = PH_SEND_HI;
                    m_byte = gc;
                    m_cur  = gd;
                    m_last = g;
                end
            end
            PH_SEND_HI, PH_SEND_LO: begin
                // Last cycle allowed in the wait state before giving up.
                m_deadline = now + T;
                m_ph = (m_ph == PH_SEND_HI) ? PH_WAIT_HI : PH_WAIT_LO;
            end
            PH_WAIT_HI, PH_WAIT_LO: begin
                if (tx_done) begin
                    if (m_ph == PH_WAIT_HI) begin
                        m_ph   = PH_SEND_LO;
                        m_byte = m_cur;
                    end else begin
                        m_ph = PH_IDLE;
                    end
                end else if (now == m_deadline) begin
                    m_ph = PH_TIMEOUT;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    task automatic step();
        tx_done = spur || (resp_en && (cyc_no == done_at));
        @(posedge clk);
        #1;
        cyc_no++;
        model_update(cyc_no - 1);
        check("dv", tx_dv, (m_ph == PH_SEND_HI) || (m_ph == PH_SEND_LO));
        check("tx_byte", tx_byte, m_byte);
        check("busy", busy, m_ph != PH_IDLE);
        check("timeout", timeout, m_ph == PH_TIMEOUT);
        check("req_busy", req_busy, m_pend);
        check("drop", drop, m_drop);
        if (tx_dv) dv_log.push_back('{cyc: cyc_no, b: tx_byte});
        if (drop[1]) drop1_cnt++;
        if ((m_ph == PH_SEND_HI) || (m_ph == PH_SEND_LO)) begin
            done_at = cyc_no + (rand_dly ? int'($urandom_range(1, 20)) : 10);
        end
        rst       = 1'b0;
        req_valid = '0;
        spur      = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        dv_log.delete();
        done_at   = -1;
        drop1_cnt = 0;
    endtask

    task automatic wait_dv(input int n, input int max_cyc, input string tag);
        int c = 0;
        while (dv_log.size() < n && c < max_cyc) begin
            step();
            c++;
        end
        check({tag, "_reached"}, dv_log.size() >= n, 1'b1);
    endtask

    // exp holds the expected bytes first-to-last, most significant first.
    task automatic check_log(input string tag, input logic [63:0] exp, input int n);
        logic [7:0] got;
        check({tag, "_count"}, dv_log.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < dv_log.size()) ? dv_log[i].b : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), got, exp[8*(n-1-i) +: 8]);
        end
    endtask

    initial begin
        int t0;
        int to_cyc;
        int n;

        // Reset state
        do_reset();
        check("reset_busy", busy, 1'b0);
        check("reset_req_busy", req_busy, 4'h0);
        check("reset_byte", tx_byte, 8'h00);

        // Single frame
        req_valid = 4'b0001;
        req_code  = 32'h0000_0008;
        req_data  = 32'h0000_001A;
        t0 = cyc_no;
        step();
        wait_dv(1, 10, "single");
        check("single_latency", (dv_log.size() > 0) ? dv_log[0].cyc : -1, t0 + 2);
        run(30);
        check_log("single", {8'h08, 8'h1A}, 2);
        check("single_idle", busy, 1'b0);

        // Round robin
        do_reset();
        req_valid = 4'b1111;
        req_code  = 32'h1312_1110;
        req_data  = 32'h2322_2120;
        step();
        run(110);
        check_log("rr4", {8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23}, 8);
        dv_log.delete();
        req_valid = 4'b1001;
        req_code  = 32'h3300_0030;
        req_data  = 32'h4300_0040;
        step();
        run(60);
        check_log("rr2", {8'h30, 8'h40, 8'h33, 8'h43}, 4);

        // Overflow and accept-in-grant-cycle
        do_reset();
        req_valid = 4'b0001;
        req_code  = 32'h0000_0040;
        req_data  = 32'h0000_0050;
        step();
        req_valid = 4'b0010;
        req_code  = 32'h0000_4100;
        req_data  = 32'h0000_5100;
        step();
        req_valid = 4'b0010;
        req_code  = 32'h0000_4200;
        req_data  = 32'h0000_5200;
        step();
        for (int i = 0; i < 60 && !(m_ph == PH_IDLE && m_pend[1]); i++) step();
        req_valid = 4'b0010;
        req_code  = 32'h0000_4300;
        req_data  = 32'h0000_5300;
        step();
        run(60);
        check("ovf_drop_count", drop1_cnt, 1);
        check_log("ovf", {8'h40, 8'h50, 8'h41, 8'h51, 8'h43, 8'h53}, 6);

        // Timeout
        do_reset();
        resp_en   = 1'b0;
        req_valid = 4'b0001;
        req_code  = 32'h0000_0060;
        req_data  = 32'h0000_0070;
        step();
        req_valid = 4'b0100;
        req_code  = 32'h0062_0000;
        req_data  = 32'h0072_0000;
        step();
        n = 0;
        while (!timeout && n < 40) begin
            step();
            n++;
        end
        to_cyc = cyc_no;
        check("to_seen", timeout, 1'b1);
        check("to_wait_cycles", (dv_log.size() > 0) ? to_cyc - dv_log[0].cyc - 1 : -1, T);
        check("to_single_dv", dv_log.size(), 1);
        resp_en = 1'b1;
        run(40);
        check_log("to", {8'h60, 8'h62, 8'h72}, 3);

        // Reset in the middle of a frame
        do_reset();
        req_valid = 4'b0001;
        req_code  = 32'h0000_0080;
        req_data  = 32'h0000_0081;
        step();
        req_valid = 4'b1100;
        req_code  = 32'h8382_0000;
        req_data  = 32'h8584_0000;
        step();
        wait_dv(2, 40, "rst_lo");
        step();
        rst = 1'b1;
        step();
        done_at = -1;
        check("rst_dv", tx_dv, 1'b0);
        check("rst_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_req_busy", req_busy, 4'h0);
        check("rst_drop", drop, 4'h0);
        dv_log.delete();
        req_valid = 4'b1100;
        req_code  = 32'h9392_0000;
        req_data  = 32'hA3A2_0000;
        step();
        run(60);
        check_log("rst_after", {8'h92, 8'hA2, 8'h93, 8'hA3}, 4);

        // Spurious done in idle and in the send cycle
        do_reset();
        spur = 1'b1;
        step();
        run(2);
        req_valid = 4'b0001;
        req_code  = 32'h0000_00B0;
        req_data  = 32'h0000_00C0;
        step();
        wait_dv(1, 10, "spur_hi");
        spur = 1'b1;
        step();
        run(30);
        check_log("spur", {8'hB0, 8'hC0}, 2);
        check("spur_gap", (dv_log.size() > 1) ? dv_log[1].cyc - dv_log[0].cyc : -1, 11);

        // Random traffic with random done delays, spurious dones and resets
        do_reset();
        rand_dly = 1'b1;
        repeat (2000) begin
            req_valid = 4'($urandom) & 4'($urandom) & 4'($urandom);
            req_code  = $urandom;
            req_data  = $urandom;
            spur      = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
